// File: rtl/conv1_engine.sv
// First convolution layer engine: 2-tap stride-1 conv + bias, ReLU, requantize and
// saturate, streamed position-major over a valid/ready handshake.
module conv1_engine #(
    parameter int IN_LEN    = 256,
    parameter int N_FILTERS = 20,
    parameter int SHIFT     = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(IN_LEN)-1:0]   in_addr,
    input  logic signed [15:0]          in_data,
    output logic                        w_start,
    output logic [4:0]                  input_filter,
    input  logic signed [15:0]          w0,
    input  logic signed [15:0]          w1,
    input  logic signed [31:0]          b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [15:0]          out_data,
    output logic [$clog2(IN_LEN)-1:0]   out_pos,
    output logic [4:0]                  out_filter
);

    localparam int AW = $clog2(IN_LEN);
    localparam logic [4:0]    F_LAST = 5'(N_FILTERS - 1);
    localparam logic [AW-1:0] N_LAST = AW'(IN_LEN - 2);

    typedef enum logic [2:0] {IDLE, RD0, RD1, CAPT, CALC, EMIT, FIN} state_t;

    state_t state, state_nxt;

    logic [AW-1:0]      n;
    logic [4:0]         f;
    logic signed [15:0] x0, x1;
    logic signed [33:0] acc;
    logic signed [31:0] p0, p1;
    logic signed [33:0] acc_nxt;
    logic signed [33:0] acc_shr;
    logic signed [15:0] sat_data;

    // Products are full 32-bit; the sum is widened to 34 bits so it can never wrap.
    assign p0      = x0 * w0;
    assign p1      = x1 * w1;
    assign acc_nxt = {{2{p0[31]}}, p0} + {{2{p1[31]}}, p1} + {{2{b[31]}}, b};
    assign acc_shr = acc >>> SHIFT;

    always_comb begin
        sat_data = '0;
        if (acc[33])
            sat_data = '0;
        else if (acc_shr > 34'sd32767)
            sat_data = 16'sd32767;
        else
            sat_data = acc_shr[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = RD0;
            RD0:  state_nxt = RD1;
            RD1:  state_nxt = CAPT;
            CAPT: state_nxt = CALC;
            CALC: state_nxt = EMIT;
            EMIT: begin
                if (out_ready) begin
                    if (f < F_LAST)
                        state_nxt = CALC;
                    else if (n < N_LAST)
                        state_nxt = RD0;
                    else
                        state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters and operand registers; fields stay frozen while EMIT stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            n   <= '0;
            f   <= '0;
            x0  <= '0;
            x1  <= '0;
            acc <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        n <= '0;
                        f <= '0;
                    end
                end
                RD1:  x0  <= in_data;
                CAPT: x1  <= in_data;
                CALC: acc <= acc_nxt;
                EMIT: begin
                    if (out_ready) begin
                        if (f < F_LAST) begin
                            f <= f + 5'd1;
                        end else if (n < N_LAST) begin
                            f <= '0;
                            n <= n + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        in_addr      = '0;
        w_start      = 1'b0;
        input_filter = '0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_pos      = '0;
        out_filter   = '0;
        unique case (state)
            RD0: begin
                busy    = 1'b1;
                in_addr = n;
            end
            RD1: begin
                busy    = 1'b1;
                in_addr = n + AW'(1);
            end
            CAPT: busy = 1'b1;
            CALC: begin
                busy         = 1'b1;
                w_start      = 1'b1;
                input_filter = f;
            end
            EMIT: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                out_data   = sat_data;
                out_pos    = n;
                out_filter = f;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

endmodule
